led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen.sv | 96 +++++++++
 tb/tb_led_pattern_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Multi-channel LED pattern generator driven by one shared prescaler.
//   Each channel runs independently in one of four modes: off, on, blink,
//   or one-shot.
//   The step period of a channel is (div+1) base ticks. One base tick is
//   HALF_FREQ clk cycles.
//
// Ports
//   clk        system clock; all logic runs on its rising edge
//   rst_btn    asynchronous active-high reset
//   cfg_valid  configuration request
//   cfg_ready  high whenever out of reset (configuration always accepted)
//   cfg_ch     target channel index; indices >= N_CH are ignored
//   cfg_mode   00 off, 01 on, 10 blink, 11 one-shot
//   cfg_div    tick divider for the channel's step period
//   led        registered LED drive, bit i = channel i
module led_pattern_gen #(
  parameter int N_CH      = 4,
  parameter int HALF_FREQ = 50_000_000,
  parameter int W         = 27,
  parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_btn,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [1:0]      cfg_mode,
  input  logic [7:0]      cfg_div,
  output logic [N_CH-1:0] led
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  logic [W-1:0] presc;
  logic         tick;
  logic         accept;

  assign tick   = (presc == W'(HALF_FREQ - 1));
  assign accept = cfg_valid && cfg_ready;

  // Free-running prescaler; configuration never disturbs it.
  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      presc     <= '0;
      cfg_ready <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      if (tick) presc <= '0;
      else      presc <= presc + W'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    mode_t      mode_q;
    logic [7:0] div_q;
    logic [7:0] cnt_q;
    logic       led_q;

    // Configuration takes priority over a coincident tick, so a tick on the
    // accept edge never counts towards the first step.
    always_ff @(posedge clk or posedge rst_btn) begin
      if (rst_btn) begin
        mode_q <= MODE_OFF;
        div_q  <= '0;
        cnt_q  <= '0;
        led_q  <= 1'b0;
      end else if (accept && (cfg_ch == CH_W'(g))) begin
        mode_q <= mode_t'(cfg_mode);
        div_q  <= cfg_div;
        cnt_q  <= '0;
        led_q  <= (cfg_mode != MODE_OFF);
      end else if (tick && (mode_q == MODE_BLINK || mode_q == MODE_ONESHOT)) begin
        if (cnt_q == div_q) begin
          cnt_q <= '0;
          if (mode_q == MODE_BLINK) begin
            led_q <= ~led_q;
          end else begin
            led_q  <= 1'b0;
            mode_q <= MODE_OFF;
          end
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end

    assign led[g] = led_q;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;
  localparam int N_CH = 3;
  localparam int HF   = 10;

  logic       clk = 1'b0;
  logic       rst_btn;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_div;
  logic [2:0] led;

  int checks = 0;
  int errors = 0;

  led_pattern_gen #(.N_CH(N_CH), .HALF_FREQ(HF), .W(4)) dut (
    .clk(clk), .rst_btn(rst_btn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_div(cfg_div), .led(led)
  );

  always #4 clk = ~clk;

  // Model: k = edges since reset release, T = base ticks seen.
  // Each channel remembers its mode, divider and the tick count at accept.
  // The LED is derived from the number of whole step periods elapsed.
  int k = 0;
  int T = 0;
  int md[N_CH];
  int dv[N_CH];
  int ta[N_CH];
  logic [2:0] exp_led = '0;
  logic       exp_ready = 1'b0;

  function automatic logic model_led(int c);
    int n;
    n = T - ta[c];
    case (md[c])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((n / (dv[c] + 1)) % 2) == 0;
      default: return n < (dv[c] + 1);
    endcase
  endfunction

  always @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      k = 0;
      T = 0;
      exp_ready = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        md[i] = 0;
        dv[i] = 0;
        ta[i] = 0;
      end
    end else begin
      k++;
      if (k % HF == 0) T++;
      if (cfg_valid && exp_ready && int'(cfg_ch) < N_CH) begin
        md[cfg_ch] = int'(cfg_mode);
        dv[cfg_ch] = int'(cfg_div);
        ta[cfg_ch] = T;
      end
      exp_ready = 1'b1;
    end
    for (int i = 0; i < N_CH; i++) exp_led[i] = model_led(i);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, exp, k, $time);
    end
  endtask

  // Per-cycle compare, 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    chk("led", {29'd0, led}, {29'd0, exp_led});
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, exp_ready});
  end

  task automatic step_to(input int t);
    while (k < t) @(negedge clk);
  endtask

  task automatic accept(input int at, input int ch, input int mode, input int d);
    step_to(at - 1);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_div   = 8'(d);
    step_to(at);
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_btn   = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = '0;
    cfg_div   = '0;
    repeat (3) @(negedge clk);
    chk("rst led", {29'd0, led}, 32'd0);
    chk("rst ready", {31'd0, cfg_ready}, 32'd0);
    rst_btn = 1'b0;

    // ch0 blink div0: on at accept, toggles at ticks on edges 10, 20, ...
    accept(2, 0, 2, 0);
    chk("ch0 on at accept", {31'd0, led[0]}, 32'd1);
    step_to(9);
    chk("ch0 before tick", {31'd0, led[0]}, 32'd1);
    step_to(10);
    chk("ch0 first toggle", {31'd0, led[0]}, 32'd0);

    // ch1 blink div2 at edge 11: third tick after accept (edge 40) toggles
    accept(11, 1, 2, 2);
    chk("ch1 on at accept", {31'd0, led[1]}, 32'd1);
    step_to(39);
    chk("ch1 before step", {31'd0, led[1]}, 32'd1);
    step_to(40);
    chk("ch1 first toggle", {31'd0, led[1]}, 32'd0);
    chk("ch0 at edge 40", {31'd0, led[0]}, 32'd1);

    // ch2 one-shot div1 at edge 45: off at the 2nd tick (edge 60)
    accept(45, 2, 3, 1);
    chk("ch2 on at accept", {31'd0, led[2]}, 32'd1);
    step_to(59);
    chk("ch2 before shot", {31'd0, led[2]}, 32'd1);
    step_to(60);
    chk("ch2 shot done", {31'd0, led[2]}, 32'd0);
    step_to(260);
    chk("ch2 stays off", {31'd0, led[2]}, 32'd0);

    // Out-of-range channel: no change anywhere
    accept(265, 3, 1, 0);

    // ch0 off on a tick edge: config wins over the toggle
    step_to(290);
    chk("ch0 before off", {31'd0, led[0]}, 32'd0);
    accept(300, 0, 0, 0);
    chk("ch0 off on tick", {31'd0, led[0]}, 32'd0);

    // Restart ch0 blink mid-period
    accept(305, 0, 2, 0);
    chk("ch0 restart on", {31'd0, led[0]}, 32'd1);
    step_to(310);
    chk("ch0 restart toggle", {31'd0, led[0]}, 32'd0);

    // Restart ch1 while its step counter is non-zero
    accept(325, 1, 2, 2);
    chk("ch1 restart on", {31'd0, led[1]}, 32'd1);
    step_to(349);
    chk("ch1 restart hold", {31'd0, led[1]}, 32'd1);
    step_to(350);
    chk("ch1 restart toggle", {31'd0, led[1]}, 32'd0);

    // Asynchronous reset mid-blink, off the clock edge
    step_to(373);
    @(posedge clk);
    #3;
    rst_btn = 1'b1;
    #1;
    chk("async rst led", {29'd0, led}, 32'd0);
    chk("async rst ready", {31'd0, cfg_ready}, 32'd0);
    #99;
    @(negedge clk);
    rst_btn = 1'b0;
    #1;
    chk("ready before edge", {31'd0, cfg_ready}, 32'd0);
    @(negedge clk);
    chk("ready after edge", {31'd0, cfg_ready}, 32'd1);
    chk("led after rst", {29'd0, led}, 32'd0);

    // Prescaler restarts from 0: first tick again on edge 10
    accept(2, 0, 2, 0);
    step_to(9);
    chk("post-rst before tick", {31'd0, led[0]}, 32'd1);
    step_to(10);
    chk("post-rst toggle", {31'd0, led[0]}, 32'd0);
    step_to(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
